// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor-side bundle between the loop detectors, the traffic-light FSM and the conditioner.
// The master drives the strobe, raw detectors and light code; the slave returns the flags.
interface traffic_sensor_conditioner_if;
  logic       sample_en;
  logic [3:0] raw_det;
  logic [3:0] light_signal;
  logic       NS_S1;
  logic       SN_S1;
  logic       EW_S1;
  logic       WE_S1;
  logic       NS_S5;
  logic       SN_S5;
  logic       EW_S5;
  logic       WE_S5;
  logic [3:0] fault;

  modport master (
    output sample_en, raw_det, light_signal,
    input  NS_S1, SN_S1, EW_S1, WE_S1,
    input  NS_S5, SN_S5, EW_S5, WE_S5,
    input  fault
  );

  modport slave (
    input  sample_en, raw_det, light_signal,
    output NS_S1, SN_S1, EW_S1, WE_S1,
    output NS_S5, SN_S5, EW_S5, WE_S5,
    output fault
  );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Per-lane synchroniser, debounce and congestion dwell counter for the traffic-light FSM.
// Optional stuck-high detection is built when SENSOR_FAULT_DET_EN is defined.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CONG_THRESH     = 16,
  parameter int CNT_W           = 8,
  parameter int FAULT_CYCLES    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  traffic_sensor_conditioner_if.slave   io_sif
);

  localparam int DB_W  = 4;
  localparam int FLT_W = $clog2(FAULT_CYCLES + 1);

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_s1;
  logic [3:0] w_s5;
  logic [3:0] w_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= io_sif.raw_det;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [3:0] GREEN = 4'(2 * i + 1);

    logic [DB_W-1:0]  r_db_cnt;
    logic             r_stable;
    logic [CNT_W-1:0] r_cong_cnt;
    logic             r_s5;
    logic             r_fault;

    logic [DB_W-1:0]  w_db_inc;
    logic [DB_W-1:0]  w_db_nxt;
    logic             w_stable_nxt;
    logic [CNT_W-1:0] w_cong_nxt;
    logic             w_green;
    logic             w_fault_nxt;

    assign w_db_inc = r_db_cnt + 1'b1;
    assign w_green  = (io_sif.light_signal == GREEN);

`ifdef SENSOR_FAULT_DET_EN
    logic [FLT_W-1:0] r_stuck_cnt;
    logic [FLT_W-1:0] w_stuck_nxt;

    always_comb begin
      w_stuck_nxt = r_stuck_cnt;
      w_fault_nxt = r_fault;
      if (io_sif.sample_en) begin
        if (r_sync2[i]) begin
          if (r_stuck_cnt != FLT_W'(FAULT_CYCLES))
            w_stuck_nxt = r_stuck_cnt + 1'b1;
          if (w_stuck_nxt == FLT_W'(FAULT_CYCLES))
            w_fault_nxt = 1'b1;
        end else begin
          w_stuck_nxt = '0;
          w_fault_nxt = 1'b0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) r_stuck_cnt <= '0;
      else        r_stuck_cnt <= w_stuck_nxt;
    end
`else
    assign w_fault_nxt = 1'b0;
`endif

    always_comb begin
      w_db_nxt     = r_db_cnt;
      w_stable_nxt = r_stable;
      if (io_sif.sample_en) begin
        if (r_sync2[i] == r_stable) begin
          w_db_nxt = '0;
        end else if (w_db_inc == DB_W'(DEBOUNCE_CYCLES)) begin
          w_stable_nxt = ~r_stable;
          w_db_nxt     = '0;
        end else begin
          w_db_nxt = w_db_inc;
        end
      end
      // A faulted lane restarts debounce from absent once the sensor recovers
      if (w_fault_nxt) begin
        w_stable_nxt = 1'b0;
        w_db_nxt     = '0;
      end
    end

    // Dwell counts only ticks on which presence was already established,
    // so the tick that first sets stable does not count.
    always_comb begin
      w_cong_nxt = r_cong_cnt;
      if (w_green || w_fault_nxt) begin
        w_cong_nxt = '0;
      end else if (io_sif.sample_en) begin
        if (!w_stable_nxt)
          w_cong_nxt = '0;
        else if (r_stable && (r_cong_cnt != {CNT_W{1'b1}}))
          w_cong_nxt = r_cong_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_db_cnt   <= '0;
        r_stable   <= 1'b0;
        r_cong_cnt <= '0;
        r_s5       <= 1'b0;
        r_fault    <= 1'b0;
      end else begin
        r_db_cnt   <= w_db_nxt;
        r_stable   <= w_stable_nxt;
        r_cong_cnt <= w_cong_nxt;
        r_s5       <= (w_cong_nxt >= CNT_W'(CONG_THRESH));
        r_fault    <= w_fault_nxt;
      end
    end

    assign w_s1[i]    = r_stable;
    assign w_s5[i]    = r_s5;
    assign w_fault[i] = r_fault;
  end

  assign io_sif.NS_S1 = w_s1[0];
  assign io_sif.SN_S1 = w_s1[1];
  assign io_sif.EW_S1 = w_s1[2];
  assign io_sif.WE_S1 = w_s1[3];
  assign io_sif.NS_S5 = w_s5[0];
  assign io_sif.SN_S5 = w_s5[1];
  assign io_sif.EW_S5 = w_s5[2];
  assign io_sif.WE_S5 = w_s5[3];
  assign io_sif.fault = w_fault;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner: reset, glitch reject, congestion,
// strobe gating and counter saturation (narrow-counter second instance).
module tb_traffic_sensor_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  traffic_sensor_conditioner_if sif ();
  traffic_sensor_conditioner_if sif_sat ();

  assign sif_sat.sample_en    = sif.sample_en;
  assign sif_sat.raw_det      = sif.raw_det;
  assign sif_sat.light_signal = sif.light_signal;

  traffic_sensor_conditioner dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_sif (sif.slave)
  );

  traffic_sensor_conditioner #(.CNT_W(5), .CONG_THRESH(31)) u_sat (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_sif (sif_sat.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sif.raw_det = 4'h0;
    sif.light_signal = 4'h0;
    sif.sample_en = 1'b1;
    tick(3);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] s1v();
    return {sif.WE_S1, sif.EW_S1, sif.SN_S1, sif.NS_S1};
  endfunction

  function automatic logic [3:0] s5v();
    return {sif.WE_S5, sif.EW_S5, sif.SN_S5, sif.NS_S5};
  endfunction

  logic seen;

  initial begin
    sif.sample_en = 1'b1;
    sif.raw_det = 4'h0;
    sif.light_signal = 4'h0;

    // 1: reset holds everything clear, release timing
    rst_n = 1'b0;
    sif.raw_det = 4'hF;
    tick(5);
    chk("rst_s1", 32'(s1v()), 32'h0);
    chk("rst_s5", 32'(s5v()), 32'h0);
    chk("rst_fault", 32'(sif.fault), 32'h0);
    rst_n = 1'b1;
    tick(5);
    chk("rel_ns_s1_e5", 32'(sif.NS_S1), 32'h0);
    tick(1);
    chk("rel_ns_s1_e6", 32'(sif.NS_S1), 32'h1);

    // 2: glitch reject, then a held step
    do_reset();
    tick(2);
    sif.raw_det[2] = 1'b1;
    tick(3);
    sif.raw_det[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      seen = seen | sif.EW_S1;
    end
    chk("glitch_ew_s1", 32'(seen), 32'h0);
    sif.raw_det[2] = 1'b1;
    tick(5);
    chk("step_ew_s1_e5", 32'(sif.EW_S1), 32'h0);
    tick(1);
    chk("step_ew_s1_e6", 32'(sif.EW_S1), 32'h1);

    // 3: congestion on SN, other-lane green ignored, own green clears
    do_reset();
    sif.raw_det[1] = 1'b1;
    tick(21);
    chk("cong_sn_s5_e21", 32'(sif.SN_S5), 32'h0);
    tick(1);
    chk("cong_sn_s5_e22", 32'(sif.SN_S5), 32'h1);
    chk("cong_s1_vec", 32'(s1v()), 32'h2);
    sif.light_signal = 4'b0001;
    tick(1);
    chk("ns_green_keeps_sn_s5", 32'(sif.SN_S5), 32'h1);
    sif.light_signal = 4'b0011;
    tick(1);
    chk("sn_green_clears_s5", 32'(sif.SN_S5), 32'h0);
    chk("sn_green_keeps_s1", 32'(sif.SN_S1), 32'h1);
    sif.light_signal = 4'b0000;

    // 4: sample strobe every 4th clock on WE
    do_reset();
    sif.sample_en = 1'b0;
    sif.raw_det[3] = 1'b1;
    tick(2);
    for (int k = 1; k <= 20; k++) begin
      tick(3);
      sif.sample_en = 1'b1;
      tick(1);
      sif.sample_en = 1'b0;
      if (k == 3)  chk("gate_we_s1_t3", 32'(sif.WE_S1), 32'h0);
      if (k == 4)  chk("gate_we_s1_t4", 32'(sif.WE_S1), 32'h1);
      if (k == 19) chk("gate_we_s5_t19", 32'(sif.WE_S5), 32'h0);
      if (k == 20) chk("gate_we_s5_t20", 32'(sif.WE_S5), 32'h1);
    end
    tick(2);
    chk("gate_we_s5_hold", 32'(sif.WE_S5), 32'h1);
    sif.light_signal = 4'b0111;
    tick(1);
    chk("gate_green_clear_s5", 32'(sif.WE_S5), 32'h0);
    chk("gate_green_keep_s1", 32'(sif.WE_S1), 32'h1);
    sif.light_signal = 4'b0000;

    // 5: saturation of a 5-bit counter with threshold 31
    do_reset();
    sif.raw_det[0] = 1'b1;
    tick(22);
    chk("sat_main_ns_s5_e22", 32'(sif.NS_S5), 32'h1);
    tick(14);
    chk("sat_ns_s5_e36", 32'(sif_sat.NS_S5), 32'h0);
    tick(1);
    chk("sat_ns_s5_e37", 32'(sif_sat.NS_S5), 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      seen = seen | ~sif_sat.NS_S5;
    end
    chk("sat_no_wrap", 32'(seen), 32'h0);
    chk("sat_main_ns_s5_hold", 32'(sif.NS_S5), 32'h1);
    chk("no_fault_default", 32'(sif.fault), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traffic_sensor_conditioner.md
# traffic_sensor_conditioner

Conditions the four raw loop-detector inputs for the intersection and produces the per-lane vehicle-presence (`*_S1`) and congestion (`*_S5`) flags consumed by the traffic-light FSM. Each raw input is synchronised and debounced, and a per-lane dwell counter is run to flag congestion. The FSM's `light_signal` is fed back so that a lane's congestion count clears while that lane is being served. The block sits directly upstream of the FSM and drives its sensor inputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive sampled ticks of a changed level before `*_S1` follows it (1..15).
- `CONG_THRESH`, 16: sampled ticks of continuous presence before `*_S5` asserts (1..2^CNT_W-1).
- `CNT_W`, 8: congestion-counter width.
- `FAULT_CYCLES`, 64: stuck-high limit in sampled ticks; used only with `SENSOR_FAULT_DET_EN`.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous active-low reset.
- `sample_en` in 1: sampling strobe; debounce, congestion and fault counters advance only on clocks where it is 1.
- `raw_det` in 4: asynchronous detector inputs, bit order [0]=NS, [1]=SN, [2]=EW, [3]=WE.
- `light_signal` in 4: FSM light code.
- `NS_S1`, `SN_S1`, `EW_S1`, `WE_S1` out 1 each: debounced presence, registered.
- `NS_S5`, `SN_S5`, `EW_S5`, `WE_S5` out 1 each: congestion, registered.
- `fault` out 4: stuck-sensor flags in `raw_det` bit order.

## Operation
- **Reset.** While `rst_n`=0 at a rising edge, all flops clear: sync stages, stable levels, all counters, every `*_S1`, `*_S5` and `fault`. Reset asserted mid-count discards partial counts.
- **Synchroniser.** Each lane has 2 flops; `sync` is the second stage. It always runs and is not gated by `sample_en`.
- **Debounce.** Per lane there is a `stable` bit and a `db_cnt`. These update only on `sample_en` clocks:
  - If `sync` equals `stable`, then `db_cnt` is set to 0.
  - Otherwise, `db_cnt` is incremented. When the incremented value equals `DEBOUNCE_CYCLES`, `stable` is toggled and `db_cnt` is set to 0.
  - `*_S1` equals `stable`.
- **Congestion.** Per lane there is a `cong_cnt` of `CNT_W` bits. Rules are listed in priority order:
  1. If the lane is green, `cong_cnt` is set to 0. This is evaluated every clock, regardless of `sample_en`. Green codes: NS=4'b0001, SN=4'b0011, EW=4'b0101, WE=4'b0111. Yellow codes and 0000 do not clear the count.
  2. Else, on a `sample_en` clock with `stable`=0 (using the post-update value), `cong_cnt` is set to 0.
  3. Else, on a `sample_en` clock with `stable`=1, `cong_cnt` is incremented and saturates at 2^CNT_W-1.
  - `*_S5` is registered as (next `cong_cnt` >= `CONG_THRESH`). It updates on the same edge as the counter.
  - Therefore `*_S5`=1 implies `*_S1`=1.
- **Simultaneous events.** Green-clear together with `stable` rising gives `cong_cnt`=0 and `*_S5`=0; `*_S1` still rises. Lanes are fully independent.

## Timing
- With `sample_en` held at 1 and a raw step held steady:
  - `*_S1` changes at edge 2+`DEBOUNCE_CYCLES` after the input edge. This is 2 sync edges plus `DEBOUNCE_CYCLES` counting edges.
  - `*_S5` rises at edge 2+`DEBOUNCE_CYCLES`+`CONG_THRESH`.
- A raw glitch shorter than `DEBOUNCE_CYCLES` sampled ticks produces no output change.
- The green-lane clear of `*_S5` takes effect at the first edge at which `light_signal` shows that lane's green code.
- With `sample_en`=0, every output except the green-clear holds.

## Configuration
- **`SENSOR_FAULT_DET_EN` defined:**
  - Per lane, `stuck_cnt` increments on `sample_en` clocks while `sync`=1 and clears when `sync`=0. It saturates at `FAULT_CYCLES`.
  - When `stuck_cnt` reaches `FAULT_CYCLES`, `fault[i]` is set.
  - While `fault[i]`=1, that lane's `*_S1` and `*_S5` are forced to 0 and `cong_cnt` is held at 0.
  - `fault[i]` clears on the first `sample_en` clock with `sync`=0. Normal debounce then resumes from `stable`=0.
- **Not defined:** `fault` is tied to 4'b0000, no `stuck_cnt` logic is present, and outputs follow the debounce and congestion rules only.

## Test plan
Default parameters, `sample_en`=1 unless stated.
1. Reset: drive `raw_det`=4'hF with `rst_n`=0 for 5 clocks -> all S1/S5 and `fault` read 0. After release, NS_S1 rises exactly 6 edges later.
2. Glitch reject: 3-cycle pulse on `raw_det[2]` -> EW_S1 stays 0. A 4-or-more-cycle pulse -> EW_S1=1 at edge 6 after the input edge.
3. Congestion: hold `raw_det[1]`=1 with `light_signal`=0 -> SN_S5=1 at edge 22. Drive `light_signal`=4'b0011 -> SN_S5=0 at the next edge while SN_S1 stays 1.
4. Strobe gating: `sample_en` pulsed every 4th clock with `raw_det[3]` held -> WE_S1 at the 4th sampled tick after sync, WE_S5 at the 20th sampled tick.
5. Saturation: `CNT_W`=5, `CONG_THRESH`=31, hold presence for 100 ticks -> `cong_cnt` holds 31 and S5 stays 1 without wrapping.
6. `SENSOR_FAULT_DET_EN`: hold `raw_det[0]`=1 for 70 ticks -> `fault`=4'b0001 and NS_S1=NS_S5=0 from tick 64 after sync. Drop the input -> `fault` clears.
